// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: merges EX redirect, load-use and memory-busy
// hazards into PC/pipe-register controls, with flush/stall statistics.
// Ports: clk, rst (sync, active-high); ex_flush_req, ex_pc_src[1:0],
//   load_use_hazard, mem_busy in; pc_write, pc_src[1:0], if_id_write,
//   if_id_flush, id_ex_flush, ex_mem_hold, flush_cnt, stall_cnt out.
module pipe_flow_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_flush_req,
    input  logic [1:0]       ex_pc_src,
    input  logic             load_use_hazard,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SQUASH   = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [1:0]       pend_src_q, pend_src_d;
    logic [CNT_W-1:0] flush_cnt_q, stall_cnt_q;
    logic             flush_inc, stall_inc;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_src_d  = pend_src_q;
        pc_write    = 1'b1;
        pc_src      = 2'b00;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        flush_inc   = 1'b0;
        stall_inc   = 1'b0;

        if (mem_busy) begin
            // Freeze has top priority in every state.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            stall_inc   = 1'b1;
            state_d     = MEM_WAIT;
            // SQUASH holds a bubble in EX, so its request is not real.
            // While frozen the EX instruction does not change, so the
            // first latched redirect is kept.
            if (ex_flush_req && state_q != SQUASH && !pend_q) begin
                pend_d     = 1'b1;
                pend_src_d = ex_pc_src;
            end
        end else if (state_q == MEM_WAIT && pend_q) begin
            // Deferred redirect wins over a simultaneous request from
            // the same EX instruction.
            pc_src      = pend_src_q;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            pend_d      = 1'b0;
            state_d     = SQUASH;
        end else if (state_q == SQUASH) begin
            state_d = RUN;
        end else if (ex_flush_req) begin
            pc_src      = ex_pc_src;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = SQUASH;
        end else if (load_use_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
            state_d     = RUN;
        end else begin
            state_d = RUN;
        end

        if (rst) begin
            pc_write    = 1'b0;
            pc_src      = 2'b00;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_q      <= 1'b0;
            pend_src_q  <= 2'b00;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            if (flush_inc && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (stall_inc && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Testbench for pipe_flow_ctrl: directed scenarios plus randomized
// stimulus checked every cycle against a behavioural model.
module tb_pipe_flow_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_flush_req;
    logic [1:0]       ex_pc_src;
    logic             load_use_hazard;
    logic             mem_busy;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_hold;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: "last cycle applied a redirect", "last cycle was frozen",
    // deferred redirect and plain integer event counts.
    bit       m_bubble = 0;
    bit       m_frozen = 0;
    bit       m_pv     = 0;
    bit [1:0] m_ps     = 0;
    int       m_fl     = 0;
    int       m_st     = 0;

    pipe_flow_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_flush_req   (ex_flush_req),
        .ex_pc_src      (ex_pc_src),
        .load_use_hazard(load_use_hazard),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_hold    (ex_mem_hold),
        .flush_cnt      (flush_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Drive one cycle, compare outputs against the model, advance model.
    task automatic cyc(input bit r, input bit fr, input bit [1:0] src,
                       input bit lu, input bit mb);
        bit [7:0] e;
        bit       apply;
        @(negedge clk);
        rst             = r;
        ex_flush_req    = fr;
        ex_pc_src       = src;
        load_use_hazard = lu;
        mem_busy        = mb;
        #1;
        // e = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
        //      ex_mem_hold, 0}
        e = {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if (!r) begin
            chk("flush_cnt", int'(flush_cnt), sat(m_fl));
            chk("stall_cnt", int'(stall_cnt), sat(m_st));
        end
        apply = m_frozen && !mb && m_pv;
        if (r) begin
            e = {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            m_bubble = 0; m_frozen = 0; m_pv = 0; m_ps = 0;
            m_fl = 0; m_st = 0;
        end else if (mb) begin
            e[7] = 0; e[4] = 0; e[1] = 1;
            m_st++;
            if (fr && !m_bubble && !m_pv) begin
                m_pv = 1; m_ps = src;
            end
            m_frozen = 1; m_bubble = 0;
        end else if (apply) begin
            e[6:5] = m_ps; e[3] = 1; e[2] = 1;
            m_fl++; m_pv = 0; m_bubble = 1; m_frozen = 0;
        end else if (m_bubble) begin
            m_bubble = 0; m_frozen = 0;
        end else if (fr) begin
            e[6:5] = src; e[3] = 1; e[2] = 1;
            m_fl++; m_bubble = 1; m_frozen = 0;
        end else begin
            m_frozen = 0;
            if (lu) begin
                e[7] = 0; e[4] = 0; e[2] = 1;
                m_st++;
            end
        end
        chk("pc_write", int'(pc_write), int'(e[7]));
        chk("pc_src", int'(pc_src), int'(e[6:5]));
        chk("if_id_write", int'(if_id_write), int'(e[4]));
        chk("if_id_flush", int'(if_id_flush), int'(e[3]));
        chk("id_ex_flush", int'(id_ex_flush), int'(e[2]));
        chk("ex_mem_hold", int'(ex_mem_hold), int'(e[1]));
    endtask

    task automatic idle();
        cyc(0, 0, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 2'b00, 0, 0);
    endtask

    initial begin
        rst = 1; ex_flush_req = 0; ex_pc_src = 0;
        load_use_hazard = 0; mem_busy = 0;

        do_reset();
        chk("lit_rst_pc_write", int'(pc_write), 0);
        chk("lit_rst_if_id_flush", int'(if_id_flush), 1);
        do_reset();
        idle();
        chk("lit_rst_flush_cnt", int'(flush_cnt), 0);
        chk("lit_rst_stall_cnt", int'(stall_cnt), 0);
        chk("lit_run_pc_write", int'(pc_write), 1);

        // Redirect, then SQUASH ignores load-use.
        cyc(0, 1, 2'b10, 0, 0);
        chk("lit_redir_pc_src", int'(pc_src), 2);
        chk("lit_redir_id_ex_flush", int'(id_ex_flush), 1);
        cyc(0, 0, 2'b00, 1, 0);
        chk("lit_squash_pc_write", int'(pc_write), 1);
        chk("lit_squash_id_ex_flush", int'(id_ex_flush), 0);
        idle();
        chk("lit_redir_flush_cnt", int'(flush_cnt), 1);

        // Load-use stall.
        cyc(0, 0, 2'b00, 1, 0);
        chk("lit_lu_pc_write", int'(pc_write), 0);
        chk("lit_lu_id_ex_flush", int'(id_ex_flush), 1);
        idle();
        chk("lit_lu_stall_cnt", int'(stall_cnt), 1);
        chk("lit_lu_after_if_id_write", int'(if_id_write), 1);

        // Freeze with a deferred redirect.
        do_reset();
        cyc(0, 1, 2'b01, 0, 1);
        chk("lit_frz_hold", int'(ex_mem_hold), 1);
        cyc(0, 0, 2'b00, 0, 1);
        cyc(0, 0, 2'b00, 0, 1);
        cyc(0, 0, 2'b00, 0, 0);
        chk("lit_frz_pc_src", int'(pc_src), 1);
        chk("lit_frz_if_id_flush", int'(if_id_flush), 1);
        idle();
        chk("lit_frz_flush_cnt", int'(flush_cnt), 1);
        chk("lit_frz_stall_cnt", int'(stall_cnt), 3);

        // Redirect beats simultaneous load-use.
        do_reset();
        cyc(0, 1, 2'b10, 1, 0);
        chk("lit_sim_pc_write", int'(pc_write), 1);
        idle();
        idle();
        chk("lit_sim_stall_cnt", int'(stall_cnt), 0);
        chk("lit_sim_flush_cnt", int'(flush_cnt), 1);

        // Saturation.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 2'b00, 1, 0);
        idle();
        chk("lit_sat_stall_cnt", int'(stall_cnt), 15);

        // Reset in MEM_WAIT drops the pending redirect.
        do_reset();
        cyc(0, 1, 2'b10, 0, 1);
        do_reset();
        idle();
        chk("lit_mrst_pc_src", int'(pc_src), 0);
        chk("lit_mrst_if_id_flush", int'(if_id_flush), 0);
        chk("lit_mrst_flush_cnt", int'(flush_cnt), 0);
        chk("lit_mrst_stall_cnt", int'(stall_cnt), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 3) == 0,
                2'($urandom_range(1, 2)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Central pipeline flow controller for the 5-stage RISC-V core. It merges three hazard sources into one consistent set of PC and pipeline-register controls: the EX-stage jump/branch resolution (redirect), the load-use hazard from ID, and the multi-cycle memory busy signal. A small FSM prevents the cycle after a redirect from acting on squashed instructions and holds a redirect that arrives during a memory freeze. Saturating event counters expose flush and stall statistics.

## Interface
- CNT_W, 16, width of the flush/stall statistics counters

- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ex_flush_req  in  1  EX resolved a control transfer that requires redirect (jump, or branch with a PC change)
- ex_pc_src  in  2  PC mux select from EX for the redirect (01 branch target, 10 jump target; 00/11 not used with a redirect)
- load_use_hazard  in  1  ID instruction depends on a load currently in EX
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_write  out  1  PC register enable
- pc_src  out  2  PC mux select (00 = PC+4)
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register clears to NOP
- id_ex_flush  out  1  ID/EX register clears to NOP
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold their contents
- flush_cnt  out  CNT_W  number of redirects applied, saturating
- stall_cnt  out  CNT_W  number of stall/freeze cycles, saturating

## Operation
- States: RUN, SQUASH, MEM_WAIT. One pending-redirect register: valid bit plus 2-bit source.
- Default outputs: pc_write=1, pc_src=00, if_id_write=1, both flushes=0, ex_mem_hold=0.
- Priority in RUN, highest first:
  - mem_busy: freeze. pc_write=0, if_id_write=0, ex_mem_hold=1. If ex_flush_req is also high, latch the pending redirect. Next state is MEM_WAIT. stall_cnt increments.
  - ex_flush_req: redirect. pc_src=ex_pc_src, if_id_flush=1, id_ex_flush=1. Next state is SQUASH. flush_cnt increments.
  - load_use_hazard: pc_write=0, if_id_write=0, id_ex_flush=1. State stays RUN. stall_cnt increments.
  - Otherwise: defaults.
- SQUASH lasts one cycle. ID and EX hold bubbles, so load_use_hazard and ex_flush_req are ignored and outputs take default values. If mem_busy is high, the freeze rule applies and the next state is MEM_WAIT. Otherwise the next state is RUN.
- MEM_WAIT:
  - While mem_busy is high: freeze outputs, stall_cnt increments, and ex_flush_req is latched if seen.
  - On the first cycle with mem_busy low: if the pending redirect is valid, apply it. Use the latched source, assert both flushes, clear the pending bit, increment flush_cnt, and go to SQUASH. If not valid, evaluate the RUN rules this cycle and take the matching next state.
  - The pending redirect has priority over a simultaneous ex_flush_req. The EX instruction is the same one, so only one redirect is applied.
- Counters stop at 2^CNT_W-1 and do not wrap.

## Timing
- Reset: state=RUN, pending cleared, flush_cnt=0, stall_cnt=0.
- While rst is high: pc_write=0, pc_src=00, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_hold=0.
- All control outputs are combinational from state, pending and the inputs within the same cycle (zero latency). State, pending and counters update on the rising edge.
- A redirect costs 2 bubble cycles: the flush cycle plus the SQUASH cycle passing bubbles.
- A load-use stall lasts one cycle per assertion of load_use_hazard.
- rst asserted in any state aborts the current operation: pending is dropped and the next state is RUN.

## Test plan
- Redirect: ex_flush_req=1, ex_pc_src=10 in RUN. Same cycle: pc_src=10, if_id_flush=id_ex_flush=1. Next cycle: SQUASH outputs are default even with load_use_hazard=1. Then flush_cnt=1.
- Load-use: load_use_hazard=1 for 1 cycle. pc_write=0, if_id_write=0, id_ex_flush=1. stall_cnt=1. The following cycle has default outputs.
- Freeze plus redirect: mem_busy=1 for 3 cycles with ex_flush_req=1, ex_pc_src=01 on the first. 3 freeze cycles with ex_mem_hold=1. On the first cycle with mem_busy=0: pc_src=01, both flushes=1. Result: flush_cnt=1, stall_cnt=3.
- Simultaneous ex_flush_req and load_use_hazard in RUN: redirect wins and the load-use stall is not counted (stall_cnt unchanged).
- Saturation: with CNT_W=4, hold load_use_hazard=1 for 20 cycles. stall_cnt stops at 15.
- Mid-operation reset: assert rst in MEM_WAIT with a pending redirect. After release with mem_busy=0, no redirect occurs, outputs are default, and both counters are 0.
